// File: rtl/clken_gen_if.sv
// Reconfiguration handshake for clken_gen: the master drives a channel write and
// the block answers with ready and a one-cycle error pulse for a bad channel index.
interface clken_gen_if #(
  parameter int ACC_W = 16
) ();
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_ch;
  logic [ACC_W:0]   cfg_incr;
  logic [ACC_W-1:0] cfg_phase;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_incr, cfg_phase,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_incr, cfg_phase,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/clken_gen.sv
// Multi-channel phase-accumulator clock-enable generator: each channel carries out
// of its accumulator to produce enable pulses at refclk * incr / 2^ACC_W.
module clken_gen #(
  parameter int NUM_CH      = 3,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter logic [NUM_CH*(ACC_W+1)-1:0] INCR_INIT = {17'd8192, 17'd32768, 17'd65536}
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              sync,
  clken_gen_if.slave        cfg,
  output logic [NUM_CH-1:0] clken,
  output logic              locked
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [ACC_W:0] INCR_MAX  = {1'b1, {ACC_W{1'b0}}};
  localparam logic [7:0]     LOCK_LAST = 8'(LOCK_CYCLES - 1);
  localparam logic [3:0]     CH_LIMIT  = 4'(NUM_CH);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ACC_W:0]      incr_q [NUM_CH];
  logic [ACC_W:0]      incr_d [NUM_CH];
  logic [ACC_W-1:0]    acc_q  [NUM_CH];
  logic [ACC_W-1:0]    acc_d  [NUM_CH];
  logic [ACC_W:0]      sum    [NUM_CH];
  logic [NUM_CH-1:0]   clken_q, clken_d;
  logic                locked_q, locked_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                accept;
  logic                ch_ok;
  logic [ACC_W:0]      incr_clamped;

  assign accept       = cfg.cfg_valid && ready_q;
  assign ch_ok        = ({1'b0, cfg.cfg_ch} < CH_LIMIT);
  assign incr_clamped = (cfg.cfg_incr > INCR_MAX) ? INCR_MAX : cfg.cfg_incr;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + incr_q[i];
    end
  end

  // A write to a valid channel overrides both the normal advance and a coincident sync.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    incr_d  = incr_q;
    acc_d   = acc_q;
    clken_d = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (sync) begin
            acc_d[i]   = '0;
            clken_d[i] = 1'b0;
          end else begin
            acc_d[i]   = sum[i][ACC_W-1:0];
            clken_d[i] = sum[i][ACC_W];
          end
        end
        if (state_q == SETTLE) begin
          if (cnt_q == LOCK_LAST) begin
            state_d = LOCKED;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        if (accept) begin
          if (ch_ok) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (cfg.cfg_ch == 3'(i)) begin
                incr_d[i]  = incr_clamped;
                acc_d[i]   = cfg.cfg_phase;
                clken_d[i] = 1'b0;
              end
            end
            state_d = SETTLE;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
    locked_d = (state_d == LOCKED);
    ready_d  = (state_d != IDLE);
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      clken_q  <= '0;
      locked_q <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]  <= '0;
        incr_q[i] <= INCR_INIT[i*(ACC_W+1) +: (ACC_W+1)];
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clken_q  <= clken_d;
      locked_q <= locked_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]  <= acc_d[i];
        incr_q[i] <= incr_d[i];
      end
    end
  end

  assign clken         = clken_q;
  assign locked        = locked_q;
  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;

endmodule

// File: tb/tb_clken_gen.sv
// Self-checking bench for clken_gen: directed scenarios plus a randomized run, all
// compared against an arithmetic reference model of the enable generator.
module tb_clken_gen;
  localparam int NUM_CH      = 3;
  localparam int ACC_W       = 16;
  localparam int LOCK_CYCLES = 16;
  localparam int FULL        = 1 << ACC_W;

  logic              refclk = 1'b0;
  logic              rst    = 1'b0;
  logic              sync   = 1'b0;
  logic [NUM_CH-1:0] clken;
  logic              locked;

  clken_gen_if #(.ACC_W(ACC_W)) cfg_if ();

  clken_gen #(
    .NUM_CH(NUM_CH),
    .ACC_W(ACC_W),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .sync(sync),
    .cfg(cfg_if),
    .clken(clken),
    .locked(locked)
  );

  always #5 refclk = ~refclk;

  // Reference model: integer phase arithmetic and a countdown of edges left to lock.
  int                init_incr [NUM_CH] = '{65536, 32768, 8192};
  int                m_acc     [NUM_CH];
  int                m_incr    [NUM_CH];
  bit [NUM_CH-1:0]   m_clken;
  bit                m_running, m_locked, m_err;
  int                settle_left;
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [NUM_CH+2:0] got;

  task automatic model_reset();
    m_running   = 0;
    m_locked    = 0;
    m_err       = 0;
    m_clken     = '0;
    settle_left = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i]  = 0;
      m_incr[i] = init_incr[i];
    end
  endtask

  task automatic model_edge(input bit r, input bit s, input bit v, input int ch,
                            input int incr, input int phase);
    int t;
    if (!r) begin
      model_reset();
    end else if (!m_running) begin
      m_running   = 1;
      settle_left = LOCK_CYCLES;
      m_locked    = 0;
      m_clken     = '0;
      m_err       = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        t          = m_acc[i] + m_incr[i];
        m_clken[i] = (t >= FULL);
        m_acc[i]   = t % FULL;
        if (s) begin
          m_acc[i]   = 0;
          m_clken[i] = 0;
        end
      end
      if (!m_locked) begin
        settle_left--;
        if (settle_left == 0) m_locked = 1;
      end
      m_err = 0;
      if (v) begin
        if (ch < NUM_CH) begin
          m_incr[ch]  = (incr > FULL) ? FULL : incr;
          m_acc[ch]   = phase;
          m_clken[ch] = 0;
          settle_left = LOCK_CYCLES;
          m_locked    = 0;
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  function automatic logic [NUM_CH+2:0] model_outs();
    return {m_clken, m_locked, m_running, m_err};
  endfunction

  task automatic cycle(input bit r, input bit s, input bit v, input int ch,
                       input int incr, input int phase);
    rst              = r;
    sync             = s;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_ch    = 3'(ch);
    cfg_if.cfg_incr  = 17'(incr);
    cfg_if.cfg_phase = 16'(phase);
    @(posedge refclk);
    model_edge(r, s, v, ch, incr, phase);
    #1;
    got = {clken, locked, cfg_if.cfg_ready, cfg_if.cfg_err};
  endtask

  task automatic idle_cycle();
    cycle(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 1, k, 100 + k, 5);
      n_checks++;
      if (got !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_state k=%0d got=%b want=%b", k, got, {(NUM_CH+3){1'b0}});
      end
    end
  endtask

  task automatic test_startup();
    idle_cycle();
    n_checks++;
    if (got !== 6'b000010) begin
      n_fail++;
      $display("[TB] FAIL startup_E0 got=%b want=000010", got);
    end
    for (int k = 1; k <= 20; k++) begin
      idle_cycle();
      n_checks++;
      if (clken[0] !== 1'b1 || clken[1] !== (k % 2 == 0) || clken[2] !== (k % 8 == 0) ||
          locked !== (k >= 16) || got !== model_outs()) begin
        n_fail++;
        $display("[TB] FAIL startup E%0d got=%b want=%b", k, got, model_outs());
      end
    end
  endtask

  task automatic test_reconfig();
    cycle(1, 0, 1, 2, 16384, 0);
    n_checks++;
    if (locked !== 1'b0 || clken[2] !== 1'b0 || got !== model_outs()) begin
      n_fail++;
      $display("[TB] FAIL reconfig_T got=%b want=%b", got, model_outs());
    end
    for (int k = 1; k <= 20; k++) begin
      idle_cycle();
      n_checks++;
      if (clken[2] !== (k % 4 == 0) || locked !== (k >= 16) || got !== model_outs()) begin
        n_fail++;
        $display("[TB] FAIL reconfig T+%0d got=%b want=%b", k, got, model_outs());
      end
    end
  endtask

  task automatic test_bad_channel();
    cycle(1, 0, 1, 5, 1, 0);
    n_checks++;
    if (cfg_if.cfg_err !== 1'b1 || locked !== 1'b1 || got !== model_outs()) begin
      n_fail++;
      $display("[TB] FAIL bad_channel_err got=%b want=%b", got, model_outs());
    end
    for (int k = 1; k <= 10; k++) begin
      idle_cycle();
      n_checks++;
      if (cfg_if.cfg_err !== 1'b0 || locked !== 1'b1 || got !== model_outs()) begin
        n_fail++;
        $display("[TB] FAIL bad_channel_after k=%0d got=%b want=%b", k, got, model_outs());
      end
    end
  endtask

  task automatic test_sync();
    for (int k = 0; k < 2 && m_acc[1] != FULL / 2; k++) idle_cycle();
    cycle(1, 1, 0, 0, 0, 0);
    n_checks++;
    if (clken !== '0 || locked !== 1'b1 || got !== model_outs()) begin
      n_fail++;
      $display("[TB] FAIL sync_S got=%b want=%b", got, model_outs());
    end
    for (int k = 1; k <= 4; k++) begin
      idle_cycle();
      n_checks++;
      if (clken[1] !== (k % 2 == 0) || locked !== 1'b1 || got !== model_outs()) begin
        n_fail++;
        $display("[TB] FAIL sync S+%0d got=%b want=%b", k, got, model_outs());
      end
    end
  endtask

  task automatic test_clamp();
    cycle(1, 0, 1, 1, 70000, 0);
    n_checks++;
    if (clken[1] !== 1'b0 || got !== model_outs()) begin
      n_fail++;
      $display("[TB] FAIL clamp_write got=%b want=%b", got, model_outs());
    end
    for (int k = 1; k <= 12; k++) begin
      idle_cycle();
      n_checks++;
      if (clken[1] !== 1'b1 || got !== model_outs()) begin
        n_fail++;
        $display("[TB] FAIL clamp k=%0d got=%b want=%b", k, got, model_outs());
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, 1, (k % 2) * 2, 4096 * (k + 1), 1000 * k);
      n_checks++;
      if (locked !== 1'b0 || got !== model_outs()) begin
        n_fail++;
        $display("[TB] FAIL b2b_write k=%0d got=%b want=%b", k, got, model_outs());
      end
    end
    for (int k = 1; k <= 16; k++) begin
      idle_cycle();
      n_checks++;
      if (locked !== (k == 16) || got !== model_outs()) begin
        n_fail++;
        $display("[TB] FAIL b2b_settle k=%0d got=%b want=%b", k, got, model_outs());
      end
    end
  endtask

  task automatic test_sync_with_write();
    cycle(1, 1, 1, 0, 65536, 40000);
    n_checks++;
    if (clken !== '0 || locked !== 1'b0 || got !== model_outs()) begin
      n_fail++;
      $display("[TB] FAIL sync_write got=%b want=%b", got, model_outs());
    end
    for (int k = 1; k <= 6; k++) begin
      idle_cycle();
      n_checks++;
      if (got !== model_outs()) begin
        n_fail++;
        $display("[TB] FAIL sync_write_after k=%0d got=%b want=%b", k, got, model_outs());
      end
    end
  endtask

  task automatic test_reset_mid_settle();
    cycle(1, 0, 1, 1, 100, 9);
    idle_cycle();
    idle_cycle();
    cycle(0, 1, 1, 1, 5000, 7);
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_settle got=%b want=%b", got, {(NUM_CH+3){1'b0}});
    end
    idle_cycle();
    for (int k = 1; k <= 8; k++) begin
      idle_cycle();
      n_checks++;
      if (clken[0] !== 1'b1 || clken[1] !== (k % 2 == 0) || clken[2] !== (k % 8 == 0) ||
          got !== model_outs()) begin
        n_fail++;
        $display("[TB] FAIL reset_revert E%0d got=%b want=%b", k, got, model_outs());
      end
    end
  endtask

  task automatic test_random();
    bit r, s, v;
    int ch, incr, phase, pick;
    for (int k = 0; k < 400; k++) begin
      r    = ($urandom_range(0, 59) != 0);
      s    = m_locked && ($urandom_range(0, 9) == 0);
      v    = ($urandom_range(0, 5) == 0);
      ch   = $urandom_range(0, 7);
      pick = $urandom_range(0, 5);
      incr = (pick == 0) ? 0 : (pick == 1) ? FULL : (pick == 2) ? 70000 : $urandom_range(0, FULL);
      phase = $urandom_range(0, FULL - 1);
      cycle(r, s, v, ch, incr, phase);
      n_checks++;
      if (got !== model_outs()) begin
        n_fail++;
        $display("[TB] FAIL random k=%0d got=%b want=%b", k, got, model_outs());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_startup();
    test_reconfig();
    test_bad_channel();
    test_sync();
    test_clamp();
    test_back_to_back();
    test_sync_with_write();
    test_reset_mid_settle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
